// File: rtl/spi_slave.sv
// SPI mode-0 target (CPOL=0, CPHA=0), MSB first, WIDTH-bit frames.
// sclk, cs_n and mosi are synchronised into the clk domain and edge-detected.
// A one-word holding register feeds the tx shifter; received words are
// delivered on rx_data with a one-cycle rx_valid pulse.
module spi_slave #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  state_t                 state_q;
  logic [WIDTH-1:0]       hold_q, tx_shift_q, rx_shift_q, rx_data_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic                   reload_q, miso_q, rx_valid_q, busy_q, frame_err_q;
  logic                   tx_ready_q, overrun_q;
  logic                   tx_consume;

  // Input synchronisers plus one extra registered copy for edge detection.
  // cs_n resets to its idle (high) level so reset release never looks like
  // a chip-select edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s &  sclk_prev_q;
  assign cs_fall   = ~cs_s   &  cs_prev_q;
  assign cs_rise   =  cs_s   & ~cs_prev_q;

  // The holding register is consumed at frame start, and again on the first
  // sclk falling edge after a completed word when the frame continues. That
  // late reload lets software refill the word after seeing rx_valid.
  assign tx_consume = ((state_q == IDLE) && cs_fall) ||
                      ((state_q == SHIFT) && !cs_rise && sclk_fall && reload_q);

  // Transmit holding register: load handshake, consumption and overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q     <= '0;
      tx_ready_q <= 1'b1;
      overrun_q  <= 1'b0;
    end else begin
      if (tx_consume) begin
        hold_q     <= '0;
        tx_ready_q <= 1'b1;
      end
      if (tx_load) begin
        if (tx_ready_q || tx_consume) begin
          hold_q     <= tx_data;
          tx_ready_q <= 1'b0;
        end else begin
          overrun_q  <= 1'b1;
        end
      end
    end
  end

  // Frame state machine: shifts rx on sclk rise, tx on sclk fall, and
  // closes the frame on cs rise (which wins over any coincident sclk edge).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      bit_cnt_q   <= '0;
      reload_q    <= 1'b0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          miso_q <= 1'b0;
          if (cs_fall) begin
            tx_shift_q <= hold_q;
            miso_q     <= hold_q[WIDTH-1];
            bit_cnt_q  <= '0;
            reload_q   <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            miso_q    <= 1'b0;
            reload_q  <= 1'b0;
            bit_cnt_q <= '0;
            if (bit_cnt_q != '0) frame_err_q <= 1'b1;
          end else begin
            if (sclk_rise) begin
              rx_shift_q <= {rx_shift_q[WIDTH-2:0], mosi_s};
              if (bit_cnt_q == LAST_BIT) begin
                rx_data_q  <= {rx_shift_q[WIDTH-2:0], mosi_s};
                rx_valid_q <= 1'b1;
                bit_cnt_q  <= '0;
                reload_q   <= 1'b1;
              end else begin
                bit_cnt_q  <= bit_cnt_q + 1'b1;
              end
            end
            if (sclk_fall) begin
              if (reload_q) begin
                tx_shift_q <= hold_q;
                miso_q     <= hold_q[WIDTH-1];
                reload_q   <= 1'b0;
              end else begin
                tx_shift_q <= {tx_shift_q[WIDTH-2:0], 1'b0};
                miso_q     <= tx_shift_q[WIDTH-2];
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso      = miso_q;
  assign tx_ready  = tx_ready_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed testbench for spi_slave: a behavioural mode-0 master drives
// sclk at clk/8 and each scenario task checks its own expected values.
module tb_spi_slave;

  localparam int H = 4;  // clk cycles per sclk half period

  logic       clk = 1'b0;
  logic       rst, sclk, cs_n, mosi, tx_load;
  logic [7:0] tx_data;
  logic       miso, tx_ready, rx_valid, busy, overrun, frame_err;
  logic [7:0] rx_data;

  int checks   = 0;
  int failures = 0;
  int rx_cnt   = 0;
  int ferr_cnt = 0;

  always #5 clk = ~clk;

  spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .overrun(overrun), .frame_err(frame_err)
  );

  // Pulse counters for rx_valid and frame_err, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid)  rx_cnt   = rx_cnt + 1;
    if (frame_err) ferr_cnt = ferr_cnt + 1;
  end

  // Safety net in case the bench ever stalls.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic load_word(input logic [7:0] d);
    @(negedge clk);
    tx_data = d; tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (H) @(negedge clk);
    cs_n = 1'b1;
    repeat (2*H) @(negedge clk);
  endtask

  // Master shifts nbits of mo out MSB first and captures miso just before each rise.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = mo[i];
      repeat (H) @(negedge clk);
      mi[i] = miso;
      sclk = 1'b1;
      repeat (H) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (miso !== 1'b0) begin failures++; $display("[TB] FAIL rst_miso actual=%b expected=0", miso); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_tx_ready actual=%b expected=1", tx_ready); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL rst_rx_data actual=%h expected=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_rx_valid actual=%b expected=0", rx_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy actual=%b expected=0", busy); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL rst_overrun actual=%b expected=0", overrun); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL rst_frame_err actual=%b expected=0", frame_err); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_frame();
    logic [7:0] mi;
    int r0, f0;
    load_word(8'h3C);
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("[TB] FAIL t1_ready_after_load actual=%b expected=0", tx_ready); end
    r0 = rx_cnt; f0 = ferr_cnt;
    cs_low();
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL t1_ready_after_csfall actual=%b expected=1", tx_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL t1_busy actual=%b expected=1", busy); end
    spi_bits(8'hA5, 8, mi);
    cs_high();
    checks++; if (mi !== 8'h3C) begin failures++; $display("[TB] FAIL t1_miso_word actual=%h expected=3c", mi); end
    checks++; if (rx_data !== 8'hA5) begin failures++; $display("[TB] FAIL t1_rx_data actual=%h expected=a5", rx_data); end
    checks++; if (rx_cnt - r0 !== 1) begin failures++; $display("[TB] FAIL t1_rx_pulses actual=%0d expected=1", rx_cnt - r0); end
    checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("[TB] FAIL t1_frame_err actual=%0d expected=0", ferr_cnt - f0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL t1_busy_idle actual=%b expected=0", busy); end
  endtask

  task automatic test_no_load();
    logic [7:0] mi;
    int r0;
    r0 = rx_cnt;
    cs_low();
    spi_bits(8'hFF, 8, mi);
    cs_high();
    checks++; if (mi !== 8'h00) begin failures++; $display("[TB] FAIL t2_miso_word actual=%h expected=00", mi); end
    checks++; if (rx_data !== 8'hFF) begin failures++; $display("[TB] FAIL t2_rx_data actual=%h expected=ff", rx_data); end
    checks++; if (rx_cnt - r0 !== 1) begin failures++; $display("[TB] FAIL t2_rx_pulses actual=%0d expected=1", rx_cnt - r0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi1, mi2, first_rx;
    logic       got;
    int r0, f0;
    got = 1'b0; first_rx = 8'h00;
    load_word(8'hC3);
    r0 = rx_cnt; f0 = ferr_cnt;
    cs_low();
    fork
      begin
        spi_bits(8'h12, 8, mi1);
        spi_bits(8'h34, 8, mi2);
      end
      begin
        for (int k = 0; k < 300; k++) begin
          @(negedge clk);
          if (rx_valid) begin
            got = 1'b1; first_rx = rx_data;
            tx_data = 8'h56; tx_load = 1'b1;
            @(negedge clk);
            tx_load = 1'b0;
            break;
          end
        end
      end
    join
    cs_high();
    checks++; if (got !== 1'b1) begin failures++; $display("[TB] FAIL t3_first_rx_valid_seen actual=%b expected=1", got); end
    checks++; if (first_rx !== 8'h12) begin failures++; $display("[TB] FAIL t3_first_rx actual=%h expected=12", first_rx); end
    checks++; if (rx_data !== 8'h34) begin failures++; $display("[TB] FAIL t3_second_rx actual=%h expected=34", rx_data); end
    checks++; if (rx_cnt - r0 !== 2) begin failures++; $display("[TB] FAIL t3_rx_pulses actual=%0d expected=2", rx_cnt - r0); end
    checks++; if (mi1 !== 8'hC3) begin failures++; $display("[TB] FAIL t3_miso_word1 actual=%h expected=c3", mi1); end
    checks++; if (mi2 !== 8'h56) begin failures++; $display("[TB] FAIL t3_miso_word2 actual=%h expected=56", mi2); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL t3_tx_ready actual=%b expected=1", tx_ready); end
    checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("[TB] FAIL t3_frame_err actual=%0d expected=0", ferr_cnt - f0); end
  endtask

  task automatic test_partial_frame();
    logic [7:0] mi;
    int r0, f0;
    r0 = rx_cnt; f0 = ferr_cnt;
    cs_low();
    spi_bits(8'hE7, 5, mi);
    cs_high();
    checks++; if (ferr_cnt - f0 !== 1) begin failures++; $display("[TB] FAIL t4_frame_err_pulses actual=%0d expected=1", ferr_cnt - f0); end
    checks++; if (rx_cnt - r0 !== 0) begin failures++; $display("[TB] FAIL t4_rx_pulses actual=%0d expected=0", rx_cnt - r0); end
    checks++; if (rx_data !== 8'h34) begin failures++; $display("[TB] FAIL t4_rx_kept actual=%h expected=34", rx_data); end
    cs_low();
    spi_bits(8'h81, 8, mi);
    cs_high();
    checks++; if (rx_data !== 8'h81) begin failures++; $display("[TB] FAIL t4_next_rx actual=%h expected=81", rx_data); end
    checks++; if (rx_cnt - r0 !== 1) begin failures++; $display("[TB] FAIL t4_next_rx_pulses actual=%0d expected=1", rx_cnt - r0); end
    checks++; if (ferr_cnt - f0 !== 1) begin failures++; $display("[TB] FAIL t4_next_frame_err actual=%0d expected=1", ferr_cnt - f0); end
  endtask

  task automatic test_overrun();
    logic [7:0] mi;
    checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL t5_overrun_before actual=%b expected=0", overrun); end
    load_word(8'h11);
    load_word(8'h22);
    checks++; if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL t5_overrun_set actual=%b expected=1", overrun); end
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("[TB] FAIL t5_tx_ready actual=%b expected=0", tx_ready); end
    cs_low();
    spi_bits(8'h00, 8, mi);
    cs_high();
    checks++; if (mi !== 8'h11) begin failures++; $display("[TB] FAIL t5_miso_word actual=%h expected=11", mi); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL t5_rx_data actual=%h expected=00", rx_data); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL t5_overrun_sticky actual=%b expected=1", overrun); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL t5_tx_ready_after actual=%b expected=1", tx_ready); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] mi;
    int r0, f0;
    load_word(8'h77);
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("[TB] FAIL t6_ready_before actual=%b expected=0", tx_ready); end
    cs_low();
    spi_bits(8'hFF, 3, mi);
    @(negedge clk);
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    #1;
    checks++; if (miso !== 1'b0) begin failures++; $display("[TB] FAIL t6_miso actual=%b expected=0", miso); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL t6_tx_ready actual=%b expected=1", tx_ready); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL t6_rx_data actual=%h expected=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL t6_rx_valid actual=%b expected=0", rx_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL t6_busy actual=%b expected=0", busy); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL t6_overrun actual=%b expected=0", overrun); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL t6_frame_err actual=%b expected=0", frame_err); end
    f0 = ferr_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2*H) @(negedge clk);
    checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("[TB] FAIL t6_no_frame_err actual=%0d expected=0", ferr_cnt - f0); end
    r0 = rx_cnt;
    cs_low();
    spi_bits(8'h5A, 8, mi);
    cs_high();
    checks++; if (rx_data !== 8'h5A) begin failures++; $display("[TB] FAIL t6_rx_after actual=%h expected=5a", rx_data); end
    checks++; if (rx_cnt - r0 !== 1) begin failures++; $display("[TB] FAIL t6_rx_pulses actual=%0d expected=1", rx_cnt - r0); end
    checks++; if (mi !== 8'h00) begin failures++; $display("[TB] FAIL t6_miso_after actual=%h expected=00", mi); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_no_load();
    test_back_to_back();
    test_partial_frame();
    test_overrun();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
